bsg_wormhole_stream_control_vc: RTL and testbench
=================================================

Name: bsg_wormhole_stream_control_vc

Overview:
Per-flit header/data classifier for wormhole streams carrying up to num_vc_p interleaved virtual channels. Each channel has its own tracking context. The header length is set per packet, not fixed at elaboration. The block sits beside wormhole-to-burst / burst-to-wormhole converters and link arbiters, and drives mux selects, data-beat addressing and packet-boundary signals without buffering data.

Parameters:
len_width_p, 8, width of the wormhole len field (len = total_flits - 1)
hdr_len_width_p, 3, width of per-packet header length input; legal header length 1..2^hdr_len_width_p-1
num_vc_p, 2, number of independent channel contexts (>=1)
vc_width_lp (local), max(1, clog2(num_vc_p)), channel id width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
vc_i  in  vc_width_lp  channel of the flit currently presented
len_i  in  len_width_p  wormhole len; sampled only on a first flit
hdr_len_i  in  hdr_len_width_p  header flit count of the packet; sampled only on a first flit
link_accept_i  in  1  flit on vc_i is consumed this cycle
first_flit_o  out  1  presented flit starts a new packet on vc_i
is_hdr_o  out  1  presented flit is a header flit
is_data_o  out  1  presented flit is a data flit
last_hdr_o  out  1  presented flit is the final header flit
has_data_o  out  1  current packet on vc_i carries >=1 data flit (valid while is_hdr_o)
last_data_o  out  1  presented flit is the final data flit
last_flit_o  out  1  presented flit ends the packet
data_idx_o  out  len_width_p  zero-based data-beat index (0 when not is_data_o)
len_err_o  out  1  first flit with len_i+1 < hdr_len_i, or hdr_len_i==0

Behaviour:
- Clock is clk_i. Reset: one clock, reset_n_i asynchronous active-low. Assertion clears every context immediately to state e_hdr with hdr_cnt=0, data_cnt=0, data_idx=0. Deassertion is synchronised externally.
- Per-context registers: state {e_hdr, e_data}; hdr_cnt and data_cnt (remaining flits, count down); data_idx (count up).
- All outputs are combinational functions of the context selected by vc_i plus len_i/hdr_len_i. Latency is zero. Context update happens only on link_accept_i, on the next clk_i edge, and only for context vc_i. Other contexts hold their values.
- first_flit_o = state==e_hdr & hdr_cnt==0. On a first flit:
  - eff_hdr = (hdr_len_i==0) ? 1 : hdr_len_i
  - data_len = len_i + 1 - eff_hdr, computed at len_width_p+1 bits.
  - If the result is negative or hdr_len_i==0, then len_err_o=1 and data_len is forced to 0.
- is_hdr_o = (state==e_hdr). is_data_o = (state==e_data).
- last_hdr_o:
  - On a first flit: eff_hdr==1.
  - Otherwise: is_hdr_o & hdr_cnt==1.
- has_data_o:
  - On a first flit: data_len!=0.
  - Otherwise: is_hdr_o & data_cnt!=0.
- last_data_o = is_data_o & data_cnt==1. last_flit_o = last_data_o | (last_hdr_o & ~has_data_o).
- On an accepted first flit: hdr_cnt <= eff_hdr-1 and data_cnt <= data_len, loaded in the same cycle so there is no bubble.
  - If eff_hdr==1 and data_len!=0, state <= e_data.
  - If eff_hdr==1 and data_len==0, the context stays e_hdr with hdr_cnt=0, ready for the next packet.
- Accepted non-first header flit: hdr_cnt decrements. If last_hdr_o & has_data_o, state <= e_data.
- Accepted data flit: data_cnt decrements and data_idx increments. If last_data_o: state <= e_hdr, data_idx <= 0.
- len_i and hdr_len_i are ignored on flits that are not first flits.
- Maximum len (all ones) must not overflow: data_len arithmetic uses len_width_p+1 bits.
- num_vc_p==1: vc_i is ignored and treated as 0.
- vc_i >= num_vc_p is illegal. The bench asserts on it and the RTL behaviour is undefined.
- link_accept_i=0: outputs stay stable as long as the inputs are stable. No state changes.
- Reset asserted mid-packet: all contexts return to first-flit state immediately. Partial packets are discarded.

Test Plan:
1. Reset, then vc=0, hdr_len=1, len=3, accepting every cycle -> flit0: first/is_hdr/last_hdr/has_data; flits1-3: is_data, data_idx 0,1,2; flit3: last_data=last_flit=1; flit4 shows first_flit_o=1.
2. hdr_len=3, len=2 (header only), continuous accept -> is_hdr on 3 flits, has_data=0, last_flit on flit2, is_data never asserted.
3. Interleave vc0 (hdr_len=2, len=5) and vc1 (hdr_len=1, len=1), alternating vc_i each cycle -> each vc independently produces its own hdr/data sequence; vc1 packet ends after 2 of its flits while vc0 data_idx continues from where it was.
4. hdr_len=2, len=7, link_accept_i held low for 4 cycles on the second data flit -> outputs constant, data_idx=1 throughout stall, sequence resumes unchanged.
5. hdr_len=4, len=1 -> len_err_o=1 on first flit, data_len=0, 4 header flits, last_flit on 4th; hdr_len=0 -> treated as 1, len_err_o=1.
6. Assert reset_n_i low asynchronously (between edges) mid-data on vc0 -> first_flit_o=1 and is_data_o=0 immediately, before the next clock edge; len=255, hdr_len=1 afterwards -> 255 data flits, data_idx reaches 254, no overflow.

Source files
------------

// File: rtl/bsg_wormhole_stream_control_vc_if.sv
// Flit classification bundle: the stream side drives channel/len/header-length/accept,
// the controller returns per-flit header/data/boundary flags and the data-beat index.
interface bsg_wormhole_stream_control_vc_if #(
    parameter int len_width_p     = 8,
    parameter int hdr_len_width_p = 3,
    parameter int num_vc_p        = 2
) ();
    localparam int vc_width_lp = (num_vc_p > 1) ? $clog2(num_vc_p) : 1;

    logic [vc_width_lp-1:0]     vc_i;
    logic [len_width_p-1:0]     len_i;
    logic [hdr_len_width_p-1:0] hdr_len_i;
    logic                       link_accept_i;

    logic                       first_flit_o;
    logic                       is_hdr_o;
    logic                       is_data_o;
    logic                       last_hdr_o;
    logic                       has_data_o;
    logic                       last_data_o;
    logic                       last_flit_o;
    logic [len_width_p-1:0]     data_idx_o;
    logic                       len_err_o;

    modport master (
        output vc_i, len_i, hdr_len_i, link_accept_i,
        input  first_flit_o, is_hdr_o, is_data_o, last_hdr_o, has_data_o,
               last_data_o, last_flit_o, data_idx_o, len_err_o
    );

    modport slave (
        input  vc_i, len_i, hdr_len_i, link_accept_i,
        output first_flit_o, is_hdr_o, is_data_o, last_hdr_o, has_data_o,
               last_data_o, last_flit_o, data_idx_o, len_err_o
    );
endinterface

// File: rtl/bsg_wormhole_stream_control_vc.sv
// Per-VC wormhole header/data flit classifier; outputs are zero-latency from the selected context.
// No buffering: a context only advances on link_accept_i, so a stalled flit keeps identical outputs.
module bsg_wormhole_stream_control_vc #(
    parameter int len_width_p     = 8,
    parameter int hdr_len_width_p = 3,
    parameter int num_vc_p        = 2
) (
    input logic clk_i,
    input logic reset_n_i,
    bsg_wormhole_stream_control_vc_if.slave ctl
);
    localparam int vc_width_lp = (num_vc_p > 1) ? $clog2(num_vc_p) : 1;
    localparam int lw_lp  = len_width_p;
    localparam int lw1_lp = len_width_p + 1;
    localparam int hw_lp  = hdr_len_width_p;

    typedef enum logic {e_hdr, e_data} state_e;

    state_e                 state_q    [num_vc_p];
    state_e                 state_d    [num_vc_p];
    logic [hw_lp-1:0]       hdr_cnt_q  [num_vc_p];
    logic [hw_lp-1:0]       hdr_cnt_d  [num_vc_p];
    logic [lw_lp-1:0]       data_cnt_q [num_vc_p];
    logic [lw_lp-1:0]       data_cnt_d [num_vc_p];
    logic [lw_lp-1:0]       data_idx_q [num_vc_p];
    logic [lw_lp-1:0]       data_idx_d [num_vc_p];

    logic [vc_width_lp-1:0] vc_sel;
    state_e                 cur_state;
    logic [hw_lp-1:0]       cur_hdr_cnt;
    logic [lw_lp-1:0]       cur_data_cnt;
    logic [lw_lp-1:0]       cur_data_idx;

    logic                   first_flit;
    logic                   is_hdr;
    logic                   is_data;
    logic                   hdr_zero;
    logic [hw_lp-1:0]       eff_hdr;
    logic [lw1_lp-1:0]      len_plus1;
    logic                   len_short;
    logic                   len_bad;
    logic [lw_lp-1:0]       new_data_len;
    logic                   last_hdr;
    logic                   has_data;
    logic                   last_data;

    assign vc_sel = (num_vc_p == 1) ? '0 : ctl.vc_i;

    always_comb begin
        cur_state    = state_q[vc_sel];
        cur_hdr_cnt  = hdr_cnt_q[vc_sel];
        cur_data_cnt = data_cnt_q[vc_sel];
        cur_data_idx = data_idx_q[vc_sel];
    end

    // Underflow is detected at len_width_p+1 bits; when it does not occur the true
    // data length fits in len_width_p bits, so the narrow subtraction is exact.
    assign hdr_zero     = (ctl.hdr_len_i == '0);
    assign eff_hdr      = hdr_zero ? hw_lp'(1) : ctl.hdr_len_i;
    assign len_plus1    = {1'b0, ctl.len_i} + lw1_lp'(1);
    assign len_short    = (len_plus1 < lw1_lp'(eff_hdr));
    assign len_bad      = len_short | hdr_zero;
    assign new_data_len = len_bad ? '0 : (ctl.len_i - lw_lp'(eff_hdr) + lw_lp'(1));

    assign is_hdr     = (cur_state == e_hdr);
    assign is_data    = (cur_state == e_data);
    assign first_flit = is_hdr & (cur_hdr_cnt == '0);
    assign last_hdr   = first_flit ? (eff_hdr == hw_lp'(1))
                                   : (is_hdr & (cur_hdr_cnt == hw_lp'(1)));
    assign has_data   = first_flit ? (new_data_len != '0)
                                   : (is_hdr & (cur_data_cnt != '0));
    assign last_data  = is_data & (cur_data_cnt == lw_lp'(1));

    assign ctl.first_flit_o = first_flit;
    assign ctl.is_hdr_o     = is_hdr;
    assign ctl.is_data_o    = is_data;
    assign ctl.last_hdr_o   = last_hdr;
    assign ctl.has_data_o   = has_data;
    assign ctl.last_data_o  = last_data;
    assign ctl.last_flit_o  = last_data | (last_hdr & ~has_data);
    assign ctl.data_idx_o   = is_data ? cur_data_idx : '0;
    assign ctl.len_err_o    = first_flit & len_bad;

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        data_cnt_d = data_cnt_q;
        data_idx_d = data_idx_q;
        if (ctl.link_accept_i) begin
            if (first_flit) begin
                hdr_cnt_d[vc_sel]  = eff_hdr - hw_lp'(1);
                data_cnt_d[vc_sel] = new_data_len;
                if ((eff_hdr == hw_lp'(1)) && (new_data_len != '0)) begin
                    state_d[vc_sel] = e_data;
                end
            end else if (is_hdr) begin
                hdr_cnt_d[vc_sel] = cur_hdr_cnt - hw_lp'(1);
                if (last_hdr && has_data) begin
                    state_d[vc_sel] = e_data;
                end
            end else begin
                data_cnt_d[vc_sel] = cur_data_cnt - lw_lp'(1);
                if (last_data) begin
                    state_d[vc_sel]    = e_hdr;
                    data_idx_d[vc_sel] = '0;
                end else begin
                    data_idx_d[vc_sel] = cur_data_idx + lw_lp'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_vc_p; i++) begin
                state_q[i]    <= e_hdr;
                hdr_cnt_q[i]  <= '0;
                data_cnt_q[i] <= '0;
                data_idx_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            data_cnt_q <= data_cnt_d;
            data_idx_q <= data_idx_d;
        end
    end
endmodule

// File: tb/tb_bsg_wormhole_stream_control_vc.sv
// Directed scoreboard bench: stimulus pushes hand-derived per-flit expectations,
// a negedge monitor pops and compares the DUT's flit classification.
module tb_bsg_wormhole_stream_control_vc;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bsg_wormhole_stream_control_vc_if #(
        .len_width_p(8), .hdr_len_width_p(3), .num_vc_p(2)
    ) ifc ();

    bsg_wormhole_stream_control_vc #(
        .len_width_p(8), .hdr_len_width_p(3), .num_vc_p(2)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .ctl      (ifc)
    );

    typedef struct packed {
        logic [15:0] tag;
        logic        first;
        logic        hdr;
        logic        data;
        logic        lh;
        logic        hd;
        logic        ld;
        logic        lf;
        logic [7:0]  idx;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tag_n  = 0;

    function automatic exp_t H(logic f, logic lh, logic hd, logic lf, logic err);
        exp_t e;
        e = '0;
        e.first = f; e.hdr = 1'b1; e.lh = lh; e.hd = hd; e.lf = lf; e.err = err;
        return e;
    endfunction

    function automatic exp_t D(int idx, logic last);
        exp_t e;
        e = '0;
        e.data = 1'b1; e.ld = last; e.lf = last; e.idx = 8'(idx);
        return e;
    endfunction

    task automatic drive(input int vc, input int len, input int hl, input logic acc);
        ifc.vc_i          = 1'(vc);
        ifc.len_i         = 8'(len);
        ifc.hdr_len_i     = 3'(hl);
        ifc.link_accept_i = acc;
    endtask

    task automatic step(input int vc, input int len, input int hl, input logic acc, input exp_t e);
        @(posedge clk);
        #1;
        drive(vc, len, hl, acc);
        e.tag = 16'(tag_n);
        tag_n++;
        exp_q.push_back(e);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        ifc.link_accept_i = 1'b0;
        reset_n = 1'b1;
    endtask

    // Reset lands between edges; the check runs at the following negedge, before any clock edge.
    task automatic async_rst(input int vc, input int len, input int hl, input exp_t e);
        @(posedge clk);
        #1;
        drive(vc, len, hl, 1'b0);
        #2;
        reset_n = 1'b0;
        e.tag = 16'(tag_n);
        tag_n++;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t got;
            e = exp_q.pop_front();
            got.tag   = e.tag;
            got.first = ifc.first_flit_o;
            got.hdr   = ifc.is_hdr_o;
            got.data  = ifc.is_data_o;
            got.lh    = ifc.last_hdr_o;
            got.hd    = ifc.has_data_o;
            got.ld    = ifc.last_data_o;
            got.lf    = ifc.last_flit_o;
            got.idx   = ifc.data_idx_o;
            got.err   = ifc.len_err_o;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL flit%0d {first,hdr,data,lh,hd,ld,lf,idx,err} got=%b%b%b%b%b%b%b_%0d_%b exp=%b%b%b%b%b%b%b_%0d_%b",
                         e.tag, got.first, got.hdr, got.data, got.lh, got.hd, got.ld, got.lf, got.idx, got.err,
                         e.first, e.hdr, e.data, e.lh, e.hd, e.ld, e.lf, e.idx, e.err);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            assert (int'(ifc.vc_i) < 2) else $error("vc_i out of range");
        end
    end

    initial begin
        drive(0, 0, 1, 1'b0);

        // reset state on both channels
        step(0, 3, 1, 1'b1, H(1, 1, 1, 0, 0));
        step(1, 3, 1, 1'b1, H(1, 1, 1, 0, 0));
        release_rst();

        // 1: single header, three data beats
        step(0, 3, 1, 1'b1, H(1, 1, 1, 0, 0));
        step(0, 0, 0, 1'b1, D(0, 0));
        step(0, 0, 0, 1'b1, D(1, 0));
        step(0, 0, 0, 1'b1, D(2, 1));
        step(0, 3, 1, 1'b0, H(1, 1, 1, 0, 0));

        // 2: header-only packet, three header flits
        step(0, 2, 3, 1'b1, H(1, 0, 0, 0, 0));
        step(0, 0, 0, 1'b1, H(0, 0, 0, 0, 0));
        step(0, 0, 0, 1'b1, H(0, 1, 0, 1, 0));

        // 3: interleaved channels
        step(0, 5, 2, 1'b1, H(1, 0, 1, 0, 0));
        step(1, 1, 1, 1'b1, H(1, 1, 1, 0, 0));
        step(0, 0, 0, 1'b1, H(0, 1, 1, 0, 0));
        step(1, 0, 0, 1'b1, D(0, 1));
        step(0, 0, 0, 1'b1, D(0, 0));
        step(1, 1, 1, 1'b1, H(1, 1, 1, 0, 0));
        step(0, 0, 0, 1'b1, D(1, 0));
        step(1, 0, 0, 1'b1, D(0, 1));
        step(0, 0, 0, 1'b1, D(2, 0));
        step(0, 0, 0, 1'b1, D(3, 1));

        // 4: stall on the second data flit
        step(0, 7, 2, 1'b1, H(1, 0, 1, 0, 0));
        step(0, 0, 0, 1'b1, H(0, 1, 1, 0, 0));
        step(0, 0, 0, 1'b1, D(0, 0));
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1'b0, D(1, 0));
        step(0, 0, 0, 1'b1, D(1, 0));
        step(0, 0, 0, 1'b1, D(2, 0));
        step(0, 0, 0, 1'b1, D(3, 0));
        step(0, 0, 0, 1'b1, D(4, 0));
        step(0, 0, 0, 1'b1, D(5, 1));

        // 5: length errors on vc1
        step(1, 1, 4, 1'b1, H(1, 0, 0, 0, 1));
        step(1, 0, 0, 1'b1, H(0, 0, 0, 0, 0));
        step(1, 0, 0, 1'b1, H(0, 0, 0, 0, 0));
        step(1, 0, 0, 1'b1, H(0, 1, 0, 1, 0));
        step(1, 3, 0, 1'b1, H(1, 1, 0, 1, 1));
        step(1, 0, 1, 1'b1, H(1, 1, 0, 1, 0));

        // 6: async reset mid-packet on both channels, then maximum length
        step(1, 3, 2, 1'b1, H(1, 0, 1, 0, 0));
        step(0, 3, 1, 1'b1, H(1, 1, 1, 0, 0));
        step(0, 0, 0, 1'b1, D(0, 0));
        async_rst(0, 3, 1, H(1, 1, 1, 0, 0));
        release_rst();
        step(1, 3, 2, 1'b0, H(1, 0, 1, 0, 0));
        step(0, 255, 1, 1'b1, H(1, 1, 1, 0, 0));
        for (int i = 0; i < 255; i++) step(0, 0, 0, 1'b1, D(i, (i == 254)));
        step(0, 0, 1, 1'b0, H(1, 1, 0, 1, 0));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
